// File: rtl/systolic_pkg.sv
// systolic_pkg: feeder state type, default array sizes and the LOAD ctrl pattern
package systolic_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DRAIN} feeder_state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_ROW   = 2;
    localparam int DEF_COL   = 2;
    localparam int MAX_PE    = 64;

    // after beat k lands, only rows i <= rows-1-k keep latching from the chain
    function automatic logic [MAX_PE-1:0] ctrl_mask(input int k, input int rows, input int cols);
        ctrl_mask = '0;
        for (int j = 0; j < cols; j++)
            for (int i = 0; i < rows; i++)
                ctrl_mask[j*rows+i] = (i <= rows - 1 - k);
    endfunction

endpackage

// File: rtl/systolic_skew_line.sv
// systolic_skew_line: fixed-depth delay line used to skew one feature row
module systolic_skew_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 0
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] q_out
);

    if (DEPTH == 0) begin : g_wire
        logic unused_clk_rst;
        assign unused_clk_rst = clk_in ^ rst_in;
        assign q_out = d_in;
    end else begin : g_regs
        logic [WIDTH-1:0] taps [DEPTH];
        // shift the slot one stage per cycle
        always_ff @(posedge clk_in or posedge rst_in)
            if (rst_in) taps <= '{default: '0};
            else begin
                taps[0] <= d_in;
                for (int n = 1; n < DEPTH; n++) taps[n] <= taps[n-1];
            end
        assign q_out = taps[DEPTH-1];
    end

endmodule

// File: rtl/systolic_feeder.sv
// systolic_feeder: loads PE weights then streams features into systolic_array (SYSTOLIC_FEEDER_SKEW_EN skews rows)
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int ROW   = DEF_ROW,
    parameter int COL   = DEF_COL
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 start_in,
    input  logic                 w_valid_in,
    output logic                 w_ready_out,
    input  logic [COL*WIDTH-1:0] w_data_in,
    input  logic                 f_valid_in,
    output logic                 f_ready_out,
    input  logic [ROW*WIDTH-1:0] f_data_in,
    input  logic                 f_last_in,
    output logic [ROW*COL-1:0]   ctrl_out,
    output logic [COL*WIDTH-1:0] weight_out,
    output logic [ROW*WIDTH-1:0] feature_out,
    output logic [ROW-1:0]       feat_valid_out,
    output logic                 busy_out,
    output logic                 done_out
);

    localparam int PE = ROW * COL;
    localparam int KW = $clog2(ROW + 1);
`ifdef SYSTOLIC_FEEDER_SKEW_EN
    localparam int D = ROW - 1;
`else
    localparam int D = 0;
`endif
    localparam logic [KW-1:0] K_FULL = KW'(ROW);
    localparam logic [KW-1:0] K_LAST = KW'(ROW - 1);
    localparam logic [KW-1:0] K_D    = KW'(D);

    feeder_state_t        state;
    logic [KW-1:0]        k;
    logic [PE-1:0]        ctrl_next;
    logic                 w_acc, f_acc;
    logic [ROW*WIDTH-1:0] s0_data;
    logic [ROW-1:0]       s0_vld;

    assign w_acc = w_ready_out & w_valid_in;
    assign f_acc = f_ready_out & f_valid_in;

    // ctrl pattern to apply when the current beat is accepted
    always_comb ctrl_next = PE'(ctrl_mask(int'(k), ROW, COL));

    // job sequencer: weight load, feature stream, drain, done pulse
    always_ff @(posedge clk_in or posedge rst_in)
        if (rst_in) begin
            state       <= IDLE;
            k           <= '0;
            ctrl_out    <= '0;
            weight_out  <= '0;
            w_ready_out <= 1'b0;
            f_ready_out <= 1'b0;
            busy_out    <= 1'b0;
            done_out    <= 1'b0;
        end else begin
            done_out <= 1'b0;
            case (state)
                IDLE:
                    if (start_in) begin
                        state       <= LOAD;
                        k           <= '0;
                        ctrl_out    <= '1;
                        w_ready_out <= 1'b1;
                        busy_out    <= 1'b1;
                    end
                LOAD:
                    if (k == K_FULL) begin
                        state       <= COMPUTE;
                        ctrl_out    <= '0;
                        weight_out  <= '0;
                        f_ready_out <= 1'b1;
                    end else if (w_acc) begin
                        weight_out <= w_data_in;
                        ctrl_out   <= ctrl_next;
                        k          <= k + 1'b1;
                        if (k == K_LAST) w_ready_out <= 1'b0;
                    end
                COMPUTE:
                    if (f_acc && f_last_in) begin
                        state       <= DRAIN;
                        f_ready_out <= 1'b0;
                        k           <= '0;
                    end
                DRAIN:
                    if (k == K_D) begin
                        state    <= IDLE;
                        busy_out <= 1'b0;
                        done_out <= 1'b1;
                    end else k <= k + 1'b1;
            endcase
        end

    // first feature stage: accepted beat or an empty slot every cycle
    always_ff @(posedge clk_in or posedge rst_in)
        if (rst_in) begin
            s0_data <= '0;
            s0_vld  <= '0;
        end else begin
            s0_data <= f_acc ? f_data_in : '0;
            s0_vld  <= f_acc ? '1 : '0;
        end

`ifdef SYSTOLIC_FEEDER_SKEW_EN
    for (genvar i = 0; i < ROW; i++) begin : g_row
        systolic_skew_line #(.WIDTH(WIDTH + 1), .DEPTH(i)) u_skew (
            .clk_in (clk_in),
            .rst_in (rst_in),
            .d_in   ({s0_vld[i], s0_data[i*WIDTH +: WIDTH]}),
            .q_out  ({feat_valid_out[i], feature_out[i*WIDTH +: WIDTH]})
        );
    end
`else
    assign feature_out    = s0_data;
    assign feat_valid_out = s0_vld;
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: randomized jobs against a cycle-indexed slot model of the feeder
module tb_systolic_feeder;

    localparam int WIDTH = 8;
    localparam int ROW   = 2;
    localparam int COL   = 2;
    localparam int PE    = ROW * COL;
`ifdef SYSTOLIC_FEEDER_SKEW_EN
    localparam bit SKEW = 1'b1;
`else
    localparam bit SKEW = 1'b0;
`endif
    localparam int D = SKEW ? ROW - 1 : 0;

    logic                 clk_in = 1'b0;
    logic                 rst_in;
    logic                 start_in;
    logic                 w_valid_in;
    logic                 w_ready_out;
    logic [COL*WIDTH-1:0] w_data_in;
    logic                 f_valid_in;
    logic                 f_ready_out;
    logic [ROW*WIDTH-1:0] f_data_in;
    logic                 f_last_in;
    logic [PE-1:0]        ctrl_out;
    logic [COL*WIDTH-1:0] weight_out;
    logic [ROW*WIDTH-1:0] feature_out;
    logic [ROW-1:0]       feat_valid_out;
    logic                 busy_out;
    logic                 done_out;

    int n_chk = 0;
    int n_fail = 0;
    int c;

    logic [ROW*WIDTH-1:0] sl_d [0:255];
    logic                 sl_v [0:255];
    logic [PE-1:0]        e_ctrl;
    logic [COL*WIDTH-1:0] e_w;
    logic                 e_busy, e_done, e_fr;

    systolic_feeder #(.WIDTH(WIDTH), .ROW(ROW), .COL(COL)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .start_in       (start_in),
        .w_valid_in     (w_valid_in),
        .w_ready_out    (w_ready_out),
        .w_data_in      (w_data_in),
        .f_valid_in     (f_valid_in),
        .f_ready_out    (f_ready_out),
        .f_data_in      (f_data_in),
        .f_last_in      (f_last_in),
        .ctrl_out       (ctrl_out),
        .weight_out     (weight_out),
        .feature_out    (feature_out),
        .feat_valid_out (feat_valid_out),
        .busy_out       (busy_out),
        .done_out       (done_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // row r still loading once `beats` weights are in: its own beat (ROW-1-r) is not yet past
    function automatic logic [PE-1:0] load_mask(input int beats);
        logic [PE-1:0] m = '0;
        for (int j = 0; j < COL; j++)
            for (int r = 0; r < ROW; r++)
                m[j*ROW+r] = (r + beats <= ROW);
        return m;
    endfunction

    task automatic idle_inputs();
        logic [31:0] r;
        start_in   = 1'b0;
        w_valid_in = 1'b0;
        f_valid_in = 1'b0;
        f_last_in  = 1'b0;
        r = $urandom;
        w_data_in = r[COL*WIDTH-1:0];
        r = $urandom;
        f_data_in = r[ROW*WIDTH-1:0];
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
        c++;
    endtask

    task automatic check_all(input string ph);
        chk({ph, ".ctrl"}, ctrl_out, e_ctrl);
        chk({ph, ".weight"}, weight_out, e_w);
        chk({ph, ".busy"}, busy_out, e_busy);
        chk({ph, ".done"}, done_out, e_done);
        chk({ph, ".f_ready"}, f_ready_out, e_fr);
        for (int i = 0; i < ROW; i++) begin
            int s;
            logic [WIDTH-1:0] ed;
            logic ev;
            s  = c - 1 - (SKEW ? i : 0);
            ed = (s >= 0) ? sl_d[s][i*WIDTH +: WIDTH] : '0;
            ev = (s >= 0) ? sl_v[s] : 1'b0;
            chk($sformatf("%s.feat%0d", ph, i), feature_out[i*WIDTH +: WIDTH], ed);
            chk($sformatf("%s.fvld%0d", ph, i), feat_valid_out[i], ev);
        end
    endtask

    task automatic run_job(input int nf, input bit dir, input bit abort);
        int got;
        logic [31:0] r;
        for (int s = 0; s < 256; s++) begin
            sl_d[s] = '0;
            sl_v[s] = 1'b0;
        end
        c = 0;
        idle_inputs();
        start_in   = 1'b1;
        f_valid_in = 1'($urandom_range(0, 1));
        f_last_in  = 1'b1;
        step();
        e_ctrl = '1; e_busy = 1'b1; e_done = 1'b0; e_fr = 1'b0;
        check_all("start");
        chk("start.w_ready", w_ready_out, 1'b1);
        for (int k = 0; k < ROW; k++) begin
            int st;
            st = dir ? ((k == 1) ? 3 : 0) : int'($urandom_range(0, 3));
            repeat (st) begin
                idle_inputs();
                f_valid_in = 1'($urandom_range(0, 1));
                f_last_in  = 1'b1;
                step();
                check_all("wstall");
                chk("wstall.w_ready", w_ready_out, 1'b1);
            end
            idle_inputs();
            w_valid_in = 1'b1;
            if (dir) w_data_in = (k == 0) ? 16'h0201 : 16'h0403;
            step();
            e_w    = w_data_in;
            e_ctrl = load_mask(k + 1);
            check_all("wbeat");
            if (abort) begin
                #2 rst_in = 1'b1;
                #1;
                chk("arst.ctrl", ctrl_out, '0);
                chk("arst.weight", weight_out, '0);
                chk("arst.feature", feature_out, '0);
                chk("arst.fvld", feat_valid_out, '0);
                chk("arst.busy", busy_out, 1'b0);
                chk("arst.done", done_out, 1'b0);
                chk("arst.w_ready", w_ready_out, 1'b0);
                chk("arst.f_ready", f_ready_out, 1'b0);
                e_w = '0;
                #4 rst_in = 1'b0;
                return;
            end
        end
        idle_inputs();
        step();
        e_ctrl = '0; e_w = '0; e_fr = 1'b1;
        check_all("enter");
        got = 0;
        while (got < nf) begin
            idle_inputs();
            start_in   = 1'($urandom_range(0, 1));
            w_valid_in = 1'($urandom_range(0, 1));
            f_last_in  = 1'($urandom_range(0, 1));
            if (dir || $urandom_range(0, 2) != 0) begin
                f_valid_in = 1'b1;
                f_last_in  = (got == nf - 1);
                if (dir) f_data_in = 16'h0101;
                else begin
                    r = $urandom;
                    f_data_in = r[ROW*WIDTH-1:0];
                end
                sl_v[c] = 1'b1;
                sl_d[c] = f_data_in;
                got++;
            end
            step();
            if (got == nf) e_fr = 1'b0;
            check_all("compute");
        end
        for (int n = 0; n < D + 3; n++) begin
            idle_inputs();
            f_valid_in = 1'($urandom_range(0, 1));
            f_last_in  = 1'($urandom_range(0, 1));
            step();
            e_busy = (n < D);
            e_done = (n == D);
            check_all("drain");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_in = 1'b1;
        idle_inputs();
        c = 0;
        for (int s = 0; s < 256; s++) begin
            sl_d[s] = '0;
            sl_v[s] = 1'b0;
        end
        e_ctrl = '0; e_w = '0; e_busy = 1'b0; e_done = 1'b0; e_fr = 1'b0;
        #12;
        check_all("reset");
        chk("reset.w_ready", w_ready_out, 1'b0);
        @(negedge clk_in);
        rst_in = 1'b0;
        run_job(3, 1'b1, 1'b0);
        run_job(0 + 2, 1'b0, 1'b1);
        idle_inputs();
        e_busy = 1'b0; e_done = 1'b0; e_fr = 1'b0;
        run_job(3, 1'b1, 1'b0);
        for (int j = 0; j < 8; j++) run_job(int'($urandom_range(1, 20)), 1'b0, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
